// File: rtl/uart_pkg.sv
// Shared UART definitions: controller states and frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } tx_state_e;

    localparam int unsigned UART_FRAME_BITS = 10;
    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_DIV_115200 = 434;
    localparam int unsigned UART_BITCNT_W   = 4;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Control handshake between the TX controller (master) and the buffer/shift datapath (slave).
interface uart_tx_ctrl_if;

    logic TBR_Valid;
    logic Load;
    logic Clear_Valid;
    logic Shift;
    logic Set;
    logic Busy;
    logic Ready;
    logic Done;

    modport master (
        input  TBR_Valid,
        output Load, Clear_Valid, Shift, Set, Busy, Ready, Done
    );

    modport slave (
        output TBR_Valid,
        input  Load, Clear_Valid, Shift, Set, Busy, Ready, Done
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running 0..DIV-1 bit-period counter with synchronous clear; tick marks the last cycle.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned DIV = UART_DIV_115200
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = !clr && (cnt_q == TERM);
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit control FSM: sequences Load/Shift/Set into the shift datapath, one 8N1 frame per buffered byte.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DIV = UART_DIV_115200
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_ctrl_if.master        tx_if
);

    localparam logic [UART_BITCNT_W-1:0] LAST_BIT = UART_BITCNT_W'(UART_FRAME_BITS - 1);

    tx_state_e                state_q;
    tx_state_e                state_d;
    logic [UART_BITCNT_W-1:0] bit_q;
    logic [UART_BITCNT_W-1:0] bit_d;
    logic                     tick;
    logic                     baud_clr;
    logic                     shift;
    logic                     done;

    // Baud counter only runs in SEND so each frame starts on a fresh bit period.
    assign baud_clr = (state_q != SEND);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (baud_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_if.TBR_Valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SEND;
                bit_d   = '0;
            end
            SEND: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        // Stop bit complete; chain straight into the next byte if one is waiting.
                        done    = 1'b1;
                        bit_d   = '0;
                        state_d = tx_if.TBR_Valid ? LOAD : IDLE;
                    end else begin
                        shift = 1'b1;
                        bit_d = bit_q + UART_BITCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                bit_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
        end
    end

    assign tx_if.Load        = (state_q == LOAD);
    assign tx_if.Clear_Valid = (state_q == LOAD);
    assign tx_if.Shift       = shift;
    assign tx_if.Done        = done;
    assign tx_if.Set         = (state_q != SEND);
    assign tx_if.Busy        = (state_q != IDLE);
    assign tx_if.Ready       = (state_q != LOAD);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: DIV=4 and DIV=2 controllers, each paired with a buffer/shift datapath.
module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_ctrl_if if4 ();
    uart_tx_ctrl_if if2 ();

    uart_tx_ctrl #(.DIV(4)) dut4 (.clk(clk), .reset(reset), .tx_if(if4.master));
    uart_tx_ctrl #(.DIV(2)) dut2 (.clk(clk), .reset(reset), .tx_if(if2.master));

    // Datapaths: Clear_Valid beats a same-cycle write for the valid flag.
    logic       wr4 = 1'b0, wr2 = 1'b0;
    logic [7:0] wdata4 = 8'h00, wdata2 = 8'h00;
    logic [7:0] tbuf4, tbuf2;
    logic [9:0] sr4, sr2;
    logic       val4, val2;
    logic       tx4, tx2;
    int         viol4 = 0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbuf4 <= 8'h00; sr4 <= '1; val4 <= 1'b0;
            tbuf2 <= 8'h00; sr2 <= '1; val2 <= 1'b0;
        end else begin
            if (wr4) tbuf4 <= wdata4;
            if (if4.Clear_Valid) val4 <= 1'b0; else if (wr4) val4 <= 1'b1;
            if (if4.Load) sr4 <= {1'b1, tbuf4, 1'b0}; else if (if4.Shift) sr4 <= {1'b1, sr4[9:1]};
            if (wr2) tbuf2 <= wdata2;
            if (if2.Clear_Valid) val2 <= 1'b0; else if (wr2) val2 <= 1'b1;
            if (if2.Load) sr2 <= {1'b1, tbuf2, 1'b0}; else if (if2.Shift) sr2 <= {1'b1, sr2[9:1]};
        end
    end

    assign if4.TBR_Valid = val4;
    assign if2.TBR_Valid = val2;
    assign tx4 = if4.Set ? 1'b1 : sr4[0];
    assign tx2 = if2.Set ? 1'b1 : sr2[0];

    // Bus-side protocol monitor: writing while Ready=0 is a violation.
    always @(posedge clk) begin
        if (!reset && wr4 && !if4.Ready) viol4 <= viol4 + 1;
    end

    // {Tx, Load, Clear_Valid, Shift, Done, Set, Busy, Ready}
    logic [7:0] obs4, obs2;
    assign obs4 = {tx4, if4.Load, if4.Clear_Valid, if4.Shift, if4.Done, if4.Set, if4.Busy, if4.Ready};
    assign obs2 = {tx2, if2.Load, if2.Clear_Valid, if2.Shift, if2.Done, if2.Set, if2.Busy, if2.Ready};

    localparam logic [7:0] EXP_IDLE = 8'b1000_0101;
    localparam logic [7:0] EXP_LOAD = 8'b1110_0110;

    int checks = 0;
    int errors = 0;

    function automatic logic [7:0] get_obs(input bit s2);
        return s2 ? obs2 : obs4;
    endfunction

    // Expected outputs in SEND cycle k (1-based): bit k/DIV of {stop, data LSB first, start}.
    function automatic logic [7:0] exp_send(input logic [7:0] d, input int div, input int k);
        int   b;
        logic txb, sh, dn;
        b = (k - 1) / div;
        if (b == 0)      txb = 1'b0;
        else if (b == 9) txb = 1'b1;
        else             txb = d[b-1];
        sh = ((k % div) == 0) && (k < 10 * div);
        dn = (k == 10 * div);
        return {txb, 1'b0, 1'b0, sh, dn, 1'b0, 1'b1, 1'b1};
    endfunction

    task automatic do_write(input bit s2, input logic [7:0] d);
        if (s2) begin wdata2 = d; wr2 = 1'b1; end
        else    begin wdata4 = d; wr4 = 1'b1; end
        @(posedge clk);
        #1;
        wr2 = 1'b0;
        wr4 = 1'b0;
    endtask

    task automatic wait_load(input bit s2, input int max_cyc, input string name, output bit ok);
        logic [7:0] o;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            o = get_obs(s2);
            if (o[6]) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s load_wait: no Load within %0d cycles", name, max_cyc);
        end else begin
            checks++;
            if (o !== EXP_LOAD) begin
                errors++;
                $display("FAIL %s load_cycle: got %b want %b", name, o, EXP_LOAD);
            end
        end
    endtask

    task automatic check_frame(input bit s2, input int div, input logic [7:0] d,
                               input int max_wait, input string name);
        bit         ok;
        int         nshift;
        logic [7:0] o, e;
        wait_load(s2, max_wait, name, ok);
        if (!ok) return;
        nshift = 0;
        for (int k = 1; k <= 10 * div; k++) begin
            @(negedge clk);
            o = get_obs(s2);
            e = exp_send(d, div, k);
            if (o[4]) nshift++;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cycle %0d byte %h: got %b want %b", name, k, d, o, e);
            end
        end
        checks++;
        if (nshift != 9) begin
            errors++;
            $display("FAIL %s shift_count: got %0d want 9", name, nshift);
        end
    endtask

    task automatic check_idle(input bit s2, input string name);
        logic [7:0] o;
        @(negedge clk);
        o = get_obs(s2);
        checks++;
        if (o !== EXP_IDLE) begin
            errors++;
            $display("FAIL %s idle: got %b want %b", name, o, EXP_IDLE);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs4 !== EXP_IDLE) begin errors++; $display("FAIL reset4: got %b want %b", obs4, EXP_IDLE); end
        checks++;
        if (obs2 !== EXP_IDLE) begin errors++; $display("FAIL reset2: got %b want %b", obs2, EXP_IDLE); end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) check_idle(1'b0, "idle50");
    endtask

    task automatic test_single();
        do_write(1'b0, 8'hA5);
        check_frame(1'b0, 4, 8'hA5, 3, "single_a5");
        check_idle(1'b0, "single_a5_return");
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            do_write(1'b0, d);
            check_frame(1'b0, 4, d, 3, "random");
            check_idle(1'b0, "random_return");
        end
    endtask

    task automatic test_back_to_back();
        do_write(1'b0, 8'hA5);
        fork
            check_frame(1'b0, 4, 8'hA5, 3, "b2b_a5");
            begin
                repeat (12) @(posedge clk);
                #1;
                do_write(1'b0, 8'h3C);
            end
        join
        check_frame(1'b0, 4, 8'h3C, 1, "b2b_3c");
        check_idle(1'b0, "b2b_return");
    endtask

    task automatic test_reset_midframe();
        bit ok;
        do_write(1'b0, 8'h5A);
        wait_load(1'b0, 3, "midrst", ok);
        repeat (18) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (obs4 !== EXP_IDLE) begin errors++; $display("FAIL midrst_async: got %b want %b", obs4, EXP_IDLE); end
        @(negedge clk);
        reset = 1'b0;
        check_idle(1'b0, "midrst_after");
        do_write(1'b0, 8'hC3);
        check_frame(1'b0, 4, 8'hC3, 3, "midrst_next");
        check_idle(1'b0, "midrst_return");
    endtask

    task automatic test_load_write();
        int base;
        base = viol4;
        do_write(1'b0, 8'h11);
        fork
            check_frame(1'b0, 4, 8'h11, 3, "ldwr_11");
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (if4.Load) break;
                end
                wdata4 = 8'h22;
                wr4    = 1'b1;
                @(posedge clk);
                #1;
                wdata4 = 8'h33;
                @(posedge clk);
                #1;
                wr4 = 1'b0;
            end
        join
        check_frame(1'b0, 4, 8'h33, 1, "ldwr_33");
        check_idle(1'b0, "ldwr_return");
        checks++;
        if (viol4 - base != 1) begin
            errors++;
            $display("FAIL ldwr_violation: got %0d want 1", viol4 - base);
        end
    endtask

    task automatic test_div2();
        do_write(1'b1, 8'hFF);
        check_frame(1'b1, 2, 8'hFF, 3, "div2_ff");
        check_idle(1'b1, "div2_return");
        do_write(1'b1, 8'h81);
        check_frame(1'b1, 2, 8'h81, 3, "div2_81");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_random();
        test_back_to_back();
        test_reset_midframe();
        test_load_write();
        test_div2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Control FSM for the UART transmit path. It sequences the 8-bit transmit buffer / 10-bit shift register datapath.
- It watches the datapath's TBR_Valid flag and generates the per-bit baud timing.
- It drives Load, Shift, Set and Clear_Valid into the datapath to serialize one 8N1 frame per buffered byte, LSB first.
- Sits between the bus-side write logic, which owns TBR_en/Data_in, and the shift datapath, which produces Tx.

Parameters:
- DIV, 434, clk cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- FRAME_BITS, 10, bits per frame: start + 8 data + stop; fixed, not user-overridable.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- TBR_Valid  input  1  datapath flag: transmit buffer holds an unsent byte
- Load  output  1  one-cycle pulse: copy buffer into shift register as {1,data,0}
- Clear_Valid  output  1  one-cycle pulse, coincident with Load: clear TBR_Valid
- Shift  output  1  one-cycle pulse: shift frame right by one, fill with 1
- Set  output  1  force serial line high (idle)
- Busy  output  1  high in LOAD and SEND states
- Ready  output  1  low only in LOAD cycle; bus side must not write the buffer when Ready=0
- Done  output  1  one-cycle pulse at end of stop bit

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE; baud counter=0; bit counter=0.
  - Outputs: Set=1, Busy=0, Ready=1, Load=Shift=Clear_Valid=Done=0.
- States: IDLE, LOAD, SEND. Output decode:
  - Load and Clear_Valid: combinational decode of state==LOAD.
  - Set=1 in IDLE and LOAD, 0 in SEND.
  - Busy=(state!=IDLE); Ready=(state!=LOAD).
- IDLE: if TBR_Valid=1 -> LOAD next cycle; else stay.
- LOAD: exactly one cycle.
  - Datapath captures the frame on the clock edge ending this cycle.
  - Next state SEND; baud counter=0; bit counter=0.
- SEND:
  - Baud counter increments each cycle. Terminal count is (counter==DIV-1); at terminal count the counter wraps to 0.
  - Terminal count with bit counter<9: Shift=1 for that cycle; bit counter+1.
  - Terminal count with bit counter==9 (stop bit has been on line DIV cycles): Done=1; no Shift.
    - If TBR_Valid=1 -> LOAD (back-to-back frames).
    - Else -> IDLE.
  - The start bit appears on Tx in the first SEND cycle. Each bit is held exactly DIV cycles.
  - Frame occupancy is 10*DIV SEND cycles plus 1 LOAD cycle, so back-to-back period = 10*DIV+1 cycles.
- Exactly 9 Shift pulses per frame; Shift never asserted outside SEND.
- Shift, Load and Done are mutually exclusive in every cycle.
- TBR_Valid rising during SEND does not disturb the current frame; it is serviced at frame end.
- Write during the LOAD cycle: the datapath gives Clear_Valid priority over a buffer write, so such a write loses its valid flag. Ready=0 in that cycle exists so bus logic can stall.
- Counter widths:
  - Baud counter: clog2(DIV) bits, never exceeds DIV-1.
  - Bit counter: 4 bits, range 0..9, never exceeds 9.
- No internal dependency on Data_in; the block is data-agnostic.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, LOAD, SEND).
  - UART_FRAME_BITS=10.
  - UART_DATA_BITS=8.
  - default divisor constant UART_DIV_115200=434.
- One natural sub-module: uart_baud_tick.
  - Parameter DIV; inputs clk, reset, clr; output tick.
  - Function: counts 0..DIV-1, tick at DIV-1, clr forces count to 0.
  - Reused by the future RX controller.
- FSM and bit counter stay in uart_tx_ctrl.

Test Plan (all with DIV=4, controller paired with the shift datapath):
- Reset then idle 50 cycles, TBR_Valid=0 -> Set=1, Busy=0, Tx=1 throughout, no Load/Shift pulses.
- Write 0xA5, then hold TBR_Valid -> one LOAD cycle with Load=Clear_Valid=1; Tx over the next 40 cycles is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; exactly 9 Shift pulses; Done at cycle 40; return to IDLE.
- Write 0x3C during SEND of 0xA5 -> after Done, LOAD in the next cycle; 0x3C frame (0,0,0,1,1,1,1,0,0,1) starts with no idle gap; period 41 cycles.
- Assert reset at SEND bit 4 -> Set=1 and Busy=0 immediately (async); counters 0; next valid byte sends a complete, correct frame.
- Buffer write attempted in LOAD cycle -> Ready=0 in that cycle; checker flags the protocol violation; a write one cycle later is transmitted as the next frame.
- DIV=2 boundary build: send 0xFF -> Tx 0 then nine 1s, each bit 2 cycles, 9 Shifts, Done at cycle 20.
